gon_xbus_collector: RTL and testbench

Initiator and sink for one GON X-bus row: walks the column tags in order, enables the addressed column, and pulls a configured number of words per column off the shared bus into a small output FIFO. The GLB-side consumer drains that FIFO. Sits between a GON X-bus row (multicast controllers plus tri-state data bus) and the global buffer write port.

---
 rtl/gon_xbus_collector.sv | 152 +++++++++++++++
 tb/tb_gon_xbus_collector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gon_xbus_collector.sv
// GON X-bus row collector: walks column tags 0..last_col, enables the addressed column and
// pulls words_per_col words per column into a small output FIFO. Optional watchdog: GON_COLLECT_TIMEOUT_EN.
module gon_xbus_collector #(
    parameter int DATA_WIDTH    = 64,
    parameter int COL_TAG_WIDTH = 4,
    parameter int NUM_OF_COLS   = 14,
    parameter int FIFO_DEPTH    = 4,
    parameter int WORDS_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [COL_TAG_WIDTH-1:0] last_col,
    input  logic [WORDS_WIDTH-1:0]   words_per_col,
    output logic [COL_TAG_WIDTH-1:0] col_tag,
    output logic                     bus_enable,
    output logic                     bus_ready,
    input  logic                     bus_valid,
    input  logic [DATA_WIDTH-1:0]    bus_data,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [COL_TAG_WIDTH-1:0] MAX_COL = COL_TAG_WIDTH'(NUM_OF_COLS - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, DONE} state_t;

    state_t                   state, state_nxt;
    logic [COL_TAG_WIDTH-1:0] col_nxt, cfg_last, last_nxt;
    logic [WORDS_WIDTH-1:0]   word_cnt, cnt_nxt, cfg_words, words_nxt;
    logic                     col_end, wd_expire;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count, count_nxt;
    logic                  push, pop;

    assign push      = bus_enable & bus_ready & bus_valid;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus_data;
    end

`ifdef GON_COLLECT_TIMEOUT_EN
    logic [7:0] wd;
    logic       tmo_q;

    // Fires on the 255th consecutive stalled CAPTURE cycle of a column.
    assign wd_expire   = (state == CAPTURE) && bus_enable && !bus_valid && (wd == 8'd254);
    assign timeout_err = tmo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd    <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state != CAPTURE || push || wd_expire) wd <= '0;
            else if (!bus_valid)                       wd <= wd + 1'b1;
            if (state == IDLE && start) tmo_q <= 1'b0;
            else if (wd_expire)         tmo_q <= 1'b1;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        col_nxt   = col_tag;
        cnt_nxt   = word_cnt;
        last_nxt  = cfg_last;
        words_nxt = cfg_words;
        col_end   = 1'b0;
        case (state)
            IDLE: if (start) begin
                last_nxt  = (last_col > MAX_COL) ? MAX_COL : last_col;
                words_nxt = (words_per_col == '0) ? WORDS_WIDTH'(1) : words_per_col;
                col_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = SELECT;
            end
            SELECT: state_nxt = CAPTURE;
            CAPTURE: begin
                if (push) begin
                    cnt_nxt = word_cnt + 1'b1;
                    col_end = (cnt_nxt == cfg_words);
                end
                if (wd_expire) col_end = 1'b1;
                if (col_end) begin
                    if (col_tag == cfg_last) begin
                        state_nxt = DONE;
                    end else begin
                        col_nxt   = col_tag + 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = SELECT;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            col_tag    <= '0;
            word_cnt   <= '0;
            cfg_last   <= '0;
            cfg_words  <= '0;
            bus_enable <= 1'b0;
            bus_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            col_tag    <= col_nxt;
            word_cnt   <= cnt_nxt;
            cfg_last   <= last_nxt;
            cfg_words  <= words_nxt;
            bus_enable <= (state_nxt == CAPTURE);
            bus_ready  <= (state_nxt == CAPTURE) && (count_nxt != FULL_CNT);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
            count      <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_gon_xbus_collector.sv
// Randomized bench for gon_xbus_collector against a queue-based reference of the collection schedule.
module tb_gon_xbus_collector;
    localparam int DEPTH = 4;
    localparam int LIMIT = 4000;
    localparam int P_IDLE = 0, P_SEL = 1, P_CAP = 2, P_DONE = 3;

    logic        clk, reset, start, bus_valid, out_ready;
    logic [3:0]  last_col, col_tag;
    logic [7:0]  words_per_col;
    logic        bus_enable, bus_ready, out_valid, busy, done, timeout_err;
    logic [63:0] bus_data, out_data;

    gon_xbus_collector dut (
        .clk(clk), .reset(reset), .start(start), .last_col(last_col),
        .words_per_col(words_per_col), .col_tag(col_tag), .bus_enable(bus_enable),
        .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL sim_timeout got=stuck exp=finish");
        $fatal(1, "simulation time limit");
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    // Reference: collection phase, current column, words taken, expected FIFO contents.
    int          m_ph = P_IDLE, m_col = 0, m_cnt = 0, m_last = 0, m_wpc = 1, m_wd = 0;
    bit          m_tmo = 1'b0;
    logic [63:0] q[$];

    int p_valid = 100, p_ready = 100, hold_ready = 0, stall_col = -1, done_seen = 0;
    bit st_req = 1'b0;
    int st_lc = 0, st_wpc = 0;

    task automatic step_cycle();
        logic [9:0] exp_ctl, got_ctl;
        bit bv, ordy, xfer, pop, fin;
        logic [63:0] bd;
        int tag;
        @(negedge clk);
        tag     = m_col;
        exp_ctl = {tag[3:0], m_ph == P_CAP, (m_ph == P_CAP) && (q.size() < DEPTH),
                   m_ph != P_IDLE, m_ph == P_DONE, q.size() > 0, m_tmo};
        got_ctl = {col_tag, bus_enable, bus_ready, busy, done, out_valid, timeout_err};
        chk("ctl", 64'(got_ctl), 64'(exp_ctl));
        if (q.size() > 0) chk("data", out_data, q[0]);
        if (done) done_seen++;

        bv   = (m_ph == P_CAP && m_col == stall_col) ? 1'b0 : ($urandom_range(99) < p_valid);
        ordy = (hold_ready > 0) ? 1'b0 : ($urandom_range(99) < p_ready);
        if (hold_ready > 0) hold_ready--;
        bd = {$urandom, $urandom};
        start = st_req; last_col = 4'(st_lc); words_per_col = 8'(st_wpc);
        bus_valid = bv; bus_data = bd; out_ready = ordy;

        xfer = (m_ph == P_CAP) && (q.size() < DEPTH) && bv;
        pop  = (q.size() > 0) && ordy;
        if (pop)  void'(q.pop_front());
        if (xfer) q.push_back(bd);
        fin = 1'b0;
        case (m_ph)
            P_IDLE: if (st_req) begin
                m_last = (st_lc > 13) ? 13 : st_lc;
                m_wpc  = (st_wpc == 0) ? 1 : st_wpc;
                m_col = 0; m_cnt = 0; m_tmo = 1'b0; m_ph = P_SEL;
            end
            P_SEL: begin m_ph = P_CAP; m_wd = 0; end
            P_CAP: begin
                if (xfer) begin
                    m_cnt++; m_wd = 0;
                    if (m_cnt == m_wpc) fin = 1'b1;
                end
`ifdef GON_COLLECT_TIMEOUT_EN
                else if (!bv) begin
                    m_wd++;
                    if (m_wd == 255) begin fin = 1'b1; m_tmo = 1'b1; end
                end
`endif
                if (fin) begin
                    if (m_col == m_last) m_ph = P_DONE;
                    else begin m_col++; m_cnt = 0; m_wd = 0; m_ph = P_SEL; end
                end
            end
            default: m_ph = P_IDLE;
        endcase
        st_req = 1'b0;
    endtask

    task automatic run_case(input int lc, input int wpc, input int pv, input int pr, input int inject);
        int n;
        p_valid = pv; p_ready = pr; done_seen = 0;
        st_req = 1'b1; st_lc = lc; st_wpc = wpc;
        step_cycle();
        n = 0;
        while (!(m_ph == P_IDLE && q.size() == 0) && n < LIMIT) begin
            if (n == inject) begin
                st_req = 1'b1; st_lc = $urandom_range(15); st_wpc = $urandom_range(7);
            end
            step_cycle();
            n++;
        end
        chk("run_bound", 64'(n < LIMIT), 64'd1);
        chk("done_cnt", 64'(done_seen), 64'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; bus_valid = 1'b0; out_ready = 1'b0;
        last_col = '0; words_per_col = '0; bus_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 64'({col_tag, bus_enable, bus_ready, busy, done, out_valid, timeout_err}), 64'd0);
        chk("rst_data", out_data, 64'd0);
        reset = 1'b0;

        run_case(2, 3, 100, 100, -1);             // 9 words, back-to-back
        hold_ready = 12;
        run_case(0, 6, 100, 100, -1);             // FIFO fills, bus_ready drops
        run_case(3, 0, 70, 70, 3);                // wpc=0 -> 1 word; start while busy ignored
        run_case(15, 2, 80, 80, -1);              // last_col clamped to 13
        chk("clamp_last", 64'(col_tag), 64'd13);

        // Reset mid-capture with two words held in the FIFO.
        p_valid = 100; p_ready = 0;
        st_req = 1'b1; st_lc = 1; st_wpc = 5;
        step_cycle();
        n = 0;
        while (q.size() < 2 && n < 20) begin step_cycle(); n++; end
        chk("fifo_two", 64'(q.size()), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ctl", 64'({col_tag, bus_enable, bus_ready, busy, done, out_valid, timeout_err}), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        q.delete(); m_ph = P_IDLE; m_col = 0; m_cnt = 0; m_tmo = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_case(1, 2, 100, 100, -1);

`ifdef GON_COLLECT_TIMEOUT_EN
        stall_col = 1;
        run_case(2, 2, 100, 100, -1);
        stall_col = -1;
        chk("tmo_sticky", 64'(timeout_err), 64'd1);
        run_case(1, 1, 100, 100, -1);
        chk("tmo_clear", 64'(timeout_err), 64'd0);
`endif

        for (int i = 0; i < 10; i++)
            run_case($urandom_range(15), $urandom_range(5), 40 + $urandom_range(60), 30 + $urandom_range(70), -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
